// File: rtl/lab3_debounce_pkg.sv
// Shared types and default constants for the lab3 two-channel input debouncer.
package lab3_debounce_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        StStableLo = 2'b00,
        StWaitHi   = 2'b01,
        StStableHi = 2'b10,
        StWaitLo   = 2'b11
    } deb_state_t;

    // Accepted level: stays at the old value while a new level is still being qualified.
    function automatic logic deb_level(deb_state_t s);
        return (s == StStableHi) || (s == StWaitLo);
    endfunction

endpackage

// File: rtl/lab3_debounce_ch.sv
// One debounce channel: synchronizer chain, dwell counter and four-state FSM.
// Optional change pulse output o_chg exists only when LAB3_EDGE_PULSE_EN is defined.
module lab3_debounce_ch
    import lab3_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
`ifdef LAB3_EDGE_PULSE_EN
    output logic o_chg,
`endif
    output logic o_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    // With a one-cycle dwell the first synced sample already qualifies the new level.
    localparam bit LOAD_DONE = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;
    deb_state_t             r_state;
    deb_state_t             w_state_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_d;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StStableLo;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StStableLo: begin
                if (w_synced) begin
                    if (LOAD_DONE) begin
                        w_state_d = StStableHi;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = StWaitHi;
                        w_cnt_d   = CNT_ONE;
                    end
                end
            end
            StWaitHi: begin
                if (!w_synced) begin
                    w_state_d = StStableLo;
                    w_cnt_d   = '0;
                end else if (w_cnt_inc == CNT_DONE) begin
                    w_state_d = StStableHi;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            StStableHi: begin
                if (!w_synced) begin
                    if (LOAD_DONE) begin
                        w_state_d = StStableLo;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = StWaitLo;
                        w_cnt_d   = CNT_ONE;
                    end
                end
            end
            StWaitLo: begin
                if (w_synced) begin
                    w_state_d = StStableHi;
                    w_cnt_d   = '0;
                end else if (w_cnt_inc == CNT_DONE) begin
                    w_state_d = StStableLo;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            default: begin
                w_state_d = StStableLo;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Output is a flop of the state's level, so it lags the state by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
        end else begin
            r_level <= deb_level(r_state);
        end
    end

    assign o_level = r_level;

`ifdef LAB3_EDGE_PULSE_EN
    logic r_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= deb_level(r_state) ^ r_level;
        end
    end

    assign o_chg = r_chg;
`endif

endmodule

// File: rtl/lab3_input_debounce.sv
// Two independent debounced inputs (a, b) feeding the lab3 Y = NOT A AND B gate.
// Define LAB3_EDGE_PULSE_EN to add the a_chg/b_chg one-cycle change pulses.
module lab3_input_debounce
    import lab3_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
`ifdef LAB3_EDGE_PULSE_EN
    output logic a_chg,
    output logic b_chg,
`endif
    output logic a,
    output logic b
);

    lab3_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (a_raw),
`ifdef LAB3_EDGE_PULSE_EN
        .o_chg   (a_chg),
`endif
        .o_level (a)
    );

    lab3_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (b_raw),
`ifdef LAB3_EDGE_PULSE_EN
        .o_chg   (b_chg),
`endif
        .o_level (b)
    );

endmodule
